// File: rtl/ha_array_accumulator_if.sv
// ---------------------------------------------------------------------------
// ha_array_accumulator_if
//
// Handshake bundle between an approximate ha_array partial-product generator
// (master), the ha_array_accumulator reducer (slave) and the downstream
// product consumer.
//
// Signals
//   in_valid / in_ready      : input bundle handshake
//   ha_array_k_t  (T_W)      : sum row of group k, bit i weight 2^(2k+i)
//   ha_array_k_b  (B_W)      : carry row of group k, bit j weight 2^(2k+j+2)
//   out_valid / out_ready    : product handshake
//   product (P_W), ovf       : saturated product and overflow flag
// ---------------------------------------------------------------------------
interface ha_array_accumulator_if #(
  parameter int T_W = 9,
  parameter int B_W = 7,
  parameter int P_W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [T_W-1:0] ha_array_0_t;
  logic [T_W-1:0] ha_array_1_t;
  logic [T_W-1:0] ha_array_2_t;
  logic [T_W-1:0] ha_array_3_t;
  logic [B_W-1:0] ha_array_0_b;
  logic [B_W-1:0] ha_array_1_b;
  logic [B_W-1:0] ha_array_2_b;
  logic [B_W-1:0] ha_array_3_b;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] product;
  logic           ovf;

  // Producer of rows and consumer of the product.
  modport master (
    output in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    input  in_ready, out_valid, product, ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    output in_ready, out_valid, product, ovf
  );
endinterface

// File: rtl/ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// ha_array_accumulator
//
// Reduces the four half-adder-compressed row pairs of an unsigned 8x8
// ha_array partial-product generator to a final product. One group is added
// per cycle through a single shared adder:
//   acc += (t[k] + (b[k] << 2)) << (2k),   k = 0..3
// The result saturates to all-ones when it exceeds P_W bits.
//
// Ports
//   clk      : clock
//   rst      : asynchronous active-high reset, aborts any operation
//   bus      : ha_array_accumulator_if.slave (input/output handshakes,
//              rows, product, ovf)
//
// Timing: out_valid rises 4 edges after the accept edge; with out_ready and
// in_valid both high a new bundle is captured on the same edge the product
// is taken, giving one product every 5 cycles.
// ---------------------------------------------------------------------------
module ha_array_accumulator #(
  parameter int T_W   = 9,
  parameter int B_W   = 7,
  parameter int P_W   = 16,
  parameter int ACC_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  ha_array_accumulator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SUM, OUT} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [1:0]       idx_q;
  logic [T_W-1:0]   t_q [4];
  logic [B_W-1:0]   b_q [4];
  logic [P_W-1:0]   product_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [T_W-1:0]   t_in [4];
  logic [B_W-1:0]   b_in [4];
  logic [T_W-1:0]   t_sel;
  logic [B_W-1:0]   b_sel;
  logic [ACC_W-1:0] addend_d;
  logic [ACC_W-1:0] acc_d;
  logic             sat_d;
  logic             in_ready_d;
  logic             accept;

  assign t_in[0] = bus.ha_array_0_t;
  assign t_in[1] = bus.ha_array_1_t;
  assign t_in[2] = bus.ha_array_2_t;
  assign t_in[3] = bus.ha_array_3_t;
  assign b_in[0] = bus.ha_array_0_b;
  assign b_in[1] = bus.ha_array_1_b;
  assign b_in[2] = bus.ha_array_2_b;
  assign b_in[3] = bus.ha_array_3_b;

  // Shared adder: the selected group, aligned to weight 2^(2*idx).
  always_comb begin
    t_sel    = t_q[idx_q];
    b_sel    = b_q[idx_q];
    addend_d = (ACC_W'(t_sel) + (ACC_W'(b_sel) << 2)) << {idx_q, 1'b0};
    acc_d    = acc_q + addend_d;
    sat_d    = |acc_d[ACC_W-1:P_W];
  end

  // In OUT the slot frees up exactly when the product is taken, which is
  // what allows same-edge capture of the next bundle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_ready_d = 1'b0;
    case (state_q)
      IDLE:    in_ready_d = 1'b1;
      OUT:     in_ready_d = bus.out_ready;
      default: in_ready_d = 1'b0;
    endcase
  end

  assign accept = bus.in_valid & in_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      t_q         <= '{default: '0};
      b_q         <= '{default: '0};
      product_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of the others, independent of statement order.
      case (state_q)
        IDLE: begin
          if (accept) begin
            t_q     <= t_in;
            b_q     <= b_in;
            acc_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= SUM;
          end
        end
        SUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            product_q   <= sat_d ? '1 : acc_d[P_W-1:0];
            ovf_q       <= sat_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              t_q     <= t_in;
              b_q     <= b_in;
              acc_q   <= '0;
              idx_q   <= '0;
              ovf_q   <= 1'b0;
              state_q <= SUM;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ha_array_accumulator
//
// Directed bench for ha_array_accumulator: hand-computed products for single
// rows, mixed rows, saturation, backpressure with back-to-back capture, and
// asynchronous reset in the middle of an accumulation.
// ---------------------------------------------------------------------------
module tb_ha_array_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ha_array_accumulator_if #(.T_W(9), .B_W(7), .P_W(16)) bus ();

  ha_array_accumulator #(.T_W(9), .B_W(7), .P_W(16), .ACC_W(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rows(input logic [8:0] t0, t1, t2, t3,
                            input logic [6:0] b0, b1, b2, b3);
    bus.ha_array_0_t = t0; bus.ha_array_1_t = t1;
    bus.ha_array_2_t = t2; bus.ha_array_3_t = t3;
    bus.ha_array_0_b = b0; bus.ha_array_1_b = b1;
    bus.ha_array_2_b = b2; bus.ha_array_3_b = b3;
  endtask

  // Present in_valid, wait (bounded) for in_ready, take the accept edge,
  // then scramble the rows to show only accept-edge values matter.
  task automatic accept_bundle(input string tag);
    int n;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
    drive_rows(9'h0AA, 9'h155, 9'h0F0, 9'h10F, 7'h2A, 7'h55, 7'h33, 7'h4C);
  endtask

  // Count edges (bounded) until out_valid; returned value is the latency.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_case(input string tag,
                          input logic [8:0] t0, t1, t2, t3,
                          input logic [6:0] b0, b1, b2, b3,
                          input logic [15:0] exp_p, input logic exp_ovf);
    int lat;
    bus.out_ready = 1'b1;
    drive_rows(t0, t1, t2, t3, b0, b1, b2, b3);
    accept_bundle(tag);
    wait_out(lat);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_product"}, bus.product, exp_p);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    step();
    check({tag, "_drop_valid"}, bus.out_valid, 1'b0);
    check({tag, "_idle_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive_rows('0, '0, '0, '0, '0, '0, '0, '0);

    // Reset state.
    #12;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_product", bus.product, 16'h0000);
    check("rst_ovf", bus.ovf, 1'b0);
    rst = 1'b0;
    step();

    // Single bits and mixed rows.
    run_case("t0_1",  9'h001, 0, 0, 0, 0, 0, 0, 0, 16'h0001, 1'b0);
    run_case("mix53", 9'h005, 0, 0, 0, 0, 7'h03, 0, 0, 16'd53, 1'b0);
    run_case("b3_1",  0, 0, 0, 0, 0, 0, 0, 7'h01, 16'h0100, 1'b0);
    run_case("t3_100", 0, 0, 0, 9'h100, 0, 0, 0, 0, 16'h4000, 1'b0);

    // Saturation (acc = 1019*85 = 86615), then ovf clears on next bundle.
    run_case("sat", 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF,
             7'h7F, 7'h7F, 7'h7F, 7'h7F, 16'hFFFF, 1'b1);
    run_case("zero", 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1'b0);

    // Backpressure: 0x12 + 5*64 = 338 held for 10 cycles.
    bus.out_ready = 1'b0;
    drive_rows(9'h012, 0, 0, 0, 0, 0, 7'h05, 0);
    accept_bundle("bp");
    wait_out(lat);
    check("bp_latency", lat, 32'd4);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", bus.out_valid, 1'b1);
      check("bp_hold_product", bus.product, 16'd338);
      check("bp_hold_in_ready", bus.in_ready, 1'b0);
      step();
    end

    // Back-to-back: 7*4 + 1*4 = 32 captured on the same edge.
    drive_rows(0, 9'h007, 0, 0, 7'h01, 0, 0, 0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    drive_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check("b2b_valid_drop", bus.out_valid, 1'b0);
    check("b2b_busy", bus.in_ready, 1'b0);
    wait_out(lat);
    check("b2b_latency", lat, 32'd4);
    check("b2b_product", bus.product, 16'd32);
    check("b2b_ovf", bus.ovf, 1'b0);
    step();

    // Asynchronous reset during the 2nd SUM cycle.
    drive_rows(9'h0FF, 9'h0FF, 0, 0, 7'h3F, 0, 0, 0);
    accept_bundle("ar");
    step();
    rst = 1'b1;
    #1;
    check("ar_out_valid", bus.out_valid, 1'b0);
    check("ar_product", bus.product, 16'h0000);
    check("ar_in_ready", bus.in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // Post-reset bundle: 3*16 + 2*4 = 56.
    run_case("post_rst", 0, 0, 9'h003, 0, 7'h02, 0, 0, 0, 16'd56, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
